// File: rtl/master_bridge_pkg.sv
// Shared helpers for the master bridge async FIFO write/read controllers.
// Latency: n/a (package of constants and pure functions).
// Backpressure: n/a.
package master_bridge_pkg;

  // Pointer width is one bit wider than the storage address so that
  // full and empty can be told apart when the address bits match.
  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int DEFAULT_PTR_W      = DEFAULT_ADDR_WIDTH + 1;

  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  // Width-generic conversions: narrower values are zero-extended on the way in
  // and truncated by the caller on the way out. Leading zeros do not change
  // the result of either conversion.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/master_bridge_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus crossing into this clock domain.
// Latency: 2 clk_i edges from a settled input to q_o.
// Backpressure: none; samples every cycle.
module master_bridge_sync_2ff
  import master_bridge_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Metastability chain: only the second stage is consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/master_bridge_async_fifo_wr_ctrl.sv
// Write-side pointer/flag controller of the master bridge async FIFO.
// Latency: wclken same cycle as wr_en; wr_ptr_gray updates 1 edge later; pops seen after 2 edges.
// Backpressure: pushes are dropped while full and latch the sticky overflow flag.
module master_bridge_async_fifo_wr_ctrl
  import master_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_THR = 2
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_async,
  input  logic                  clr_ovf,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow
);

  localparam int PTR_W      = ptr_width(ADDR_WIDTH);
  localparam int FIFO_DEPTH = 1 << ADDR_WIDTH;

  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] THR_P   = PTR_W'(ALMOST_FULL_THR);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_bin_q,  wr_ptr_bin_d;
  logic [PTR_W-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic             ovf_q,         ovf_d;
  logic [PTR_W-1:0] rd_sync_gray;
  logic [PTR_W-1:0] rd_sync_bin;
  logic [PTR_W-1:0] wr_ptr_bin_inc;
  logic [PTR_W-1:0] free_entries;

  master_bridge_sync_2ff #(
    .WIDTH (PTR_W)
  ) u_rd_ptr_sync (
    .clk_i  (CLK),
    .rst_ni (RST_n),
    .d_i    (rd_ptr_gray_async),
    .q_o    (rd_sync_gray)
  );

  // Flags derive only from registers, so they cannot glitch on input activity.
  assign full = (wr_ptr_gray_q ==
                 {~rd_sync_gray[PTR_W-1:PTR_W-2], rd_sync_gray[PTR_W-3:0]});

  assign rd_sync_bin  = PTR_W'(gray2bin(32'(rd_sync_gray)));
  assign fill_level   = wr_ptr_bin_q - rd_sync_bin;
  assign free_entries = DEPTH_P - fill_level;
  assign almost_full  = (free_entries <= THR_P);

  // Strobe is also held low while reset is asserted so storage is never
  // written with a pointer that is being cleared.
  assign wclken         = wr_en & ~full & RST_n;
  assign wr_addr        = wr_ptr_bin_q[ADDR_WIDTH-1:0];
  assign wr_ptr_gray    = wr_ptr_gray_q;
  assign overflow       = ovf_q;
  assign wr_ptr_bin_inc = wr_ptr_bin_q + ONE_P;

  // Next-state: advance both pointers on an accepted push; overflow set beats clear.
  always_comb begin
    wr_ptr_bin_d  = wr_ptr_bin_q;
    wr_ptr_gray_d = wr_ptr_gray_q;
    ovf_d         = ovf_q;
    if (wclken) begin
      wr_ptr_bin_d  = wr_ptr_bin_inc;
      wr_ptr_gray_d = PTR_W'(bin2gray(32'(wr_ptr_bin_inc)));
    end
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end
  end

  // Pointer and overflow registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      ovf_q         <= 1'b0;
    end else begin
      wr_ptr_bin_q  <= wr_ptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      ovf_q         <= ovf_d;
    end
  end

endmodule

// File: tb/tb_master_bridge_async_fifo_wr_ctrl.sv
// Self-checking bench for the async FIFO write controller (ADDR_WIDTH=3).
// Two instances share inputs: threshold 2 and threshold 1.
// The driver queues the expected per-cycle outputs; a monitor compares on the falling edge.
module tb_master_bridge_async_fifo_wr_ctrl;

  logic       CLK;
  logic       RST_n;
  logic       wr_en;
  logic [3:0] rd_ptr_gray_async;
  logic       clr_ovf;

  logic       wclken,  wclken_b;
  logic [2:0] wr_addr, wr_addr_b;
  logic [3:0] wr_ptr_gray, wr_ptr_gray_b;
  logic       full,    full_b;
  logic       almost_full, almost_full_b;
  logic [3:0] fill_level, fill_level_b;
  logic       overflow, overflow_b;

  master_bridge_async_fifo_wr_ctrl #(.ADDR_WIDTH(3), .ALMOST_FULL_THR(2)) u_dut (
    .CLK(CLK), .RST_n(RST_n), .wr_en(wr_en), .rd_ptr_gray_async(rd_ptr_gray_async),
    .clr_ovf(clr_ovf), .wclken(wclken), .wr_addr(wr_addr), .wr_ptr_gray(wr_ptr_gray),
    .full(full), .almost_full(almost_full), .fill_level(fill_level), .overflow(overflow)
  );

  master_bridge_async_fifo_wr_ctrl #(.ADDR_WIDTH(3), .ALMOST_FULL_THR(1)) u_dut_thr1 (
    .CLK(CLK), .RST_n(RST_n), .wr_en(wr_en), .rd_ptr_gray_async(rd_ptr_gray_async),
    .clr_ovf(clr_ovf), .wclken(wclken_b), .wr_addr(wr_addr_b), .wr_ptr_gray(wr_ptr_gray_b),
    .full(full_b), .almost_full(almost_full_b), .fill_level(fill_level_b), .overflow(overflow_b)
  );

  typedef struct {
    logic       in_rst;
    logic       wclken;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       full;
    logic       af;
    logic       af1;
    logic [3:0] fill;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // 4-bit reflected Gray code, written out by hand.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  // Reference state: pushes accepted, two-stage view of the read pointer, overflow.
  int   m_wr  = 0;
  int   m_s1  = 0;
  int   m_s2  = 0;
  logic m_ovf = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // One cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic step(input logic rst_n, input logic we, input int rd_bin, input logic clr);
    exp_t e;
    int   diff;
    logic f;
    RST_n             = rst_n;
    wr_en             = we;
    rd_ptr_gray_async = gray_tab[rd_bin & 15];
    clr_ovf           = clr;
    if (!rst_n) begin
      m_wr = 0; m_s1 = 0; m_s2 = 0; m_ovf = 1'b0;
    end
    diff     = (m_wr - m_s2) & 15;
    f        = (diff == 8);
    e.in_rst = !rst_n;
    e.wclken = we && !f && rst_n;
    e.addr   = 3'(m_wr & 7);
    e.gray   = gray_tab[m_wr];
    e.full   = f;
    e.fill   = 4'(diff);
    e.af     = ((8 - diff) <= 2);
    e.af1    = ((8 - diff) <= 1);
    e.ovf    = m_ovf;
    exp_q.push_back(e);
    @(posedge CLK);
    if (rst_n) begin
      m_s2 = m_s1;
      m_s1 = rd_bin & 15;
      if (clr) m_ovf = 1'b0;
      if (we && f) m_ovf = 1'b1;
      if (e.wclken) m_wr = (m_wr + 1) & 15;
    end
    #1;
  endtask

  // Monitor: compares every queued expectation mid-cycle, plus single-bit Gray steps.
  initial begin
    exp_t       e;
    logic [3:0] prev_gray;
    prev_gray = 4'h0;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wclken",      32'(wclken),        32'(e.wclken));
        chk("wr_addr",     32'(wr_addr),       32'(e.addr));
        chk("wr_ptr_gray", 32'(wr_ptr_gray),   32'(e.gray));
        chk("full",        32'(full),          32'(e.full));
        chk("almost_full", 32'(almost_full),   32'(e.af));
        chk("almost_full_thr1", 32'(almost_full_b), 32'(e.af1));
        chk("fill_level",  32'(fill_level),    32'(e.fill));
        chk("overflow",    32'(overflow),      32'(e.ovf));
        if (!e.in_rst && (wr_ptr_gray !== prev_gray)) begin
          chk("gray_one_bit_step", 32'($countones(wr_ptr_gray ^ prev_gray)), 32'd1);
        end
        prev_gray = wr_ptr_gray;
      end
    end
  end

  initial begin
    RST_n = 1'b0; wr_en = 1'b0; rd_ptr_gray_async = 4'h0; clr_ovf = 1'b0;
    @(posedge CLK); #1;

    // Reset state.
    repeat (2) step(1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);

    // A few pushes, then reset asserted mid-stream with wr_en still high.
    repeat (3) step(1'b1, 1'b1, 0, 1'b0);
    repeat (2) step(1'b0, 1'b1, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);

    // Fill 8 entries with the read pointer held at 0, then observe full.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);

    // Overflow: push while full, clear, re-set, clear and set together.
    repeat (2) step(1'b1, 1'b1, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0);

    // Pop latency: one pop while full and pushing; accepted once sync2 sees it.
    repeat (3) step(1'b1, 1'b1, 1, 1'b0);
    step(1'b1, 1'b0, 1, 1'b1);
    step(1'b1, 1'b0, 1, 1'b0);

    // Thresholds: pop two more (fill 6), then push one (fill 7).
    repeat (3) step(1'b1, 1'b0, 3, 1'b0);
    step(1'b1, 1'b1, 3, 1'b0);
    repeat (2) step(1'b1, 1'b0, 3, 1'b0);

    // Drain, then 20 push/pop pairs with the read pointer tracking the writes.
    repeat (3) step(1'b1, 1'b0, m_wr, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, m_wr, 1'b0);
    repeat (3) step(1'b1, 1'b0, m_wr, 1'b0);

    // Let the monitor consume every queued expectation, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL monitor_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
